vp_controller: RTL and testbench

Sequencing controller for load value prediction in the MIPS core's MEM stage. It decides per load whether to speculate, based on a global saturating confidence counter. It holds at most one speculative load, checks the prediction against the returning D-cache data, writes the value table, and runs a fixed-length recovery sequence on a mispredict or timeout. It sits between the MEM-stage load port, the predictor value table and the D-cache response, and drives the pipeline stall and squash lines.

---
 rtl/vp_controller.sv | 236 +++++++++++++++++++++++
 tb/tb_vp_controller.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vp_controller.sv
`default_nettype none
// ============================================================================
//  Module   : vp_controller
//  Purpose  : Load value prediction sequencer for the MEM stage. It gates
//             speculation on a global saturating confidence counter, keeps at
//             most one speculative load in flight, verifies it against the
//             D-cache response, trains the value table and runs a fixed-length
//             recovery sequence on a mispredict or timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module vp_controller #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int CONF_BITS       = 2,
  parameter int RECOVERY_CYCLES = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_pc,
  input  logic                  pred_hit,
  input  logic [DATA_WIDTH-1:0] pred_data,
  input  logic                  dc_valid,
  input  logic [DATA_WIDTH-1:0] dc_data,
  output logic                  pred_out_valid,
  output logic [DATA_WIDTH-1:0] pred_out,
  output logic [ADDR_WIDTH-1:0] chk_pc,
  output logic                  vp_en,
  output logic                  ld_stall,
  output logic                  verify_ok,
  output logic                  recover,
  output logic                  recover_busy,
  output logic                  recovery_done,
  output logic                  lvpt_we,
  output logic [ADDR_WIDTH-1:0] lvpt_pc,
  output logic [DATA_WIDTH-1:0] lvpt_data,
  output logic [15:0]           stat_correct,
  output logic [15:0]           stat_wrong
);

  localparam int TMO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RCNT_W = (RECOVERY_CYCLES > 1) ? $clog2(RECOVERY_CYCLES) : 1;

  localparam logic [CONF_BITS-1:0] CONF_MAX  = '1;
  localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [RCNT_W-1:0]    RCNT_INIT = RCNT_W'(RECOVERY_CYCLES - 1);
  localparam logic [15:0]          STAT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SPEC    = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CONF_BITS-1:0]    conf_q, conf_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [RCNT_W-1:0]       rcnt_q, rcnt_d;
  logic [DATA_WIDTH-1:0]   spec_val_q, spec_val_d;
  logic [ADDR_WIDTH-1:0]   chk_pc_q, chk_pc_d;
  logic                    pred_out_valid_q, pred_out_valid_d;
  logic [DATA_WIDTH-1:0]   pred_out_q, pred_out_d;
  logic                    vp_en_q, vp_en_d;
  logic                    verify_ok_q, verify_ok_d;
  logic                    recover_q, recover_d;
  logic                    recover_busy_q, recover_busy_d;
  logic                    recovery_done_q, recovery_done_d;
  logic                    lvpt_we_q, lvpt_we_d;
  logic [ADDR_WIDTH-1:0]   lvpt_pc_q, lvpt_pc_d;
  logic [DATA_WIDTH-1:0]   lvpt_data_q, lvpt_data_d;
  logic [15:0]             stat_correct_q, stat_correct_d;
  logic [15:0]             stat_wrong_q, stat_wrong_d;

  logic start;

  // Speculate only on a confident table hit whose cache data is not already here
  always_comb begin
    start = (state_q == ST_IDLE) & ld_req & pred_hit & conf_q[CONF_BITS-1] & ~dc_valid;
  end

  // Next-state and next-output computation for the whole controller
  always_comb begin
    state_d          = state_q;
    conf_d           = conf_q;
    tmo_d            = tmo_q;
    rcnt_d           = rcnt_q;
    spec_val_d       = spec_val_q;
    chk_pc_d         = chk_pc_q;
    pred_out_valid_d = 1'b0;
    pred_out_d       = pred_out_q;
    verify_ok_d      = 1'b0;
    recover_d        = 1'b0;
    lvpt_we_d        = 1'b0;
    lvpt_pc_d        = lvpt_pc_q;
    lvpt_data_d      = lvpt_data_q;
    stat_correct_d   = stat_correct_q;
    stat_wrong_d     = stat_wrong_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d          = ST_SPEC;
          spec_val_d       = pred_data;
          chk_pc_d         = ld_pc;
          tmo_d            = '0;
          pred_out_valid_d = 1'b1;
          pred_out_d       = pred_data;
        end else if (ld_req && dc_valid) begin
          // Non-speculative load: train the table and the confidence counter
          lvpt_we_d   = 1'b1;
          lvpt_pc_d   = ld_pc;
          lvpt_data_d = dc_data;
          if (pred_hit) begin
            if (pred_data == dc_data) begin
              if (conf_q != CONF_MAX) conf_d = conf_q + CONF_BITS'(1);
            end else begin
              if (conf_q != '0) conf_d = conf_q - CONF_BITS'(1);
            end
          end
        end
      end

      ST_SPEC: begin
        // A response arriving on the timeout cycle still gets compared
        if (dc_valid) begin
          lvpt_we_d   = 1'b1;
          lvpt_pc_d   = chk_pc_q;
          lvpt_data_d = dc_data;
          if (dc_data == spec_val_q) begin
            verify_ok_d = 1'b1;
            state_d     = ST_IDLE;
            if (conf_q != CONF_MAX) conf_d = conf_q + CONF_BITS'(1);
            if (stat_correct_q != STAT_MAX) stat_correct_d = stat_correct_q + 16'd1;
          end else begin
            recover_d = 1'b1;
            state_d   = ST_RECOVER;
            rcnt_d    = RCNT_INIT;
            conf_d    = '0;
            if (stat_wrong_q != STAT_MAX) stat_wrong_d = stat_wrong_q + 16'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          recover_d = 1'b1;
          state_d   = ST_RECOVER;
          rcnt_d    = RCNT_INIT;
          conf_d    = '0;
          if (stat_wrong_q != STAT_MAX) stat_wrong_d = stat_wrong_q + 16'd1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_RECOVER: begin
        if (rcnt_q == '0) state_d = ST_IDLE;
        else              rcnt_d  = rcnt_q - RCNT_W'(1);
      end

      default: state_d = ST_IDLE;
    endcase

    // Level outputs follow the next state so they line up with the state itself
    vp_en_d         = (state_d == ST_SPEC);
    recover_busy_d  = (state_d == ST_RECOVER);
    recovery_done_d = (state_d == ST_RECOVER) && (rcnt_d == '0);
  end

  // Single register stage for state, bookkeeping and every registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      conf_q           <= '0;
      tmo_q            <= '0;
      rcnt_q           <= '0;
      spec_val_q       <= '0;
      chk_pc_q         <= '0;
      pred_out_valid_q <= 1'b0;
      pred_out_q       <= '0;
      vp_en_q          <= 1'b0;
      verify_ok_q      <= 1'b0;
      recover_q        <= 1'b0;
      recover_busy_q   <= 1'b0;
      recovery_done_q  <= 1'b0;
      lvpt_we_q        <= 1'b0;
      lvpt_pc_q        <= '0;
      lvpt_data_q      <= '0;
      stat_correct_q   <= '0;
      stat_wrong_q     <= '0;
    end else begin
      state_q          <= state_d;
      conf_q           <= conf_d;
      tmo_q            <= tmo_d;
      rcnt_q           <= rcnt_d;
      spec_val_q       <= spec_val_d;
      chk_pc_q         <= chk_pc_d;
      pred_out_valid_q <= pred_out_valid_d;
      pred_out_q       <= pred_out_d;
      vp_en_q          <= vp_en_d;
      verify_ok_q      <= verify_ok_d;
      recover_q        <= recover_d;
      recover_busy_q   <= recover_busy_d;
      recovery_done_q  <= recovery_done_d;
      lvpt_we_q        <= lvpt_we_d;
      lvpt_pc_q        <= lvpt_pc_d;
      lvpt_data_q      <= lvpt_data_d;
      stat_correct_q   <= stat_correct_d;
      stat_wrong_q     <= stat_wrong_d;
    end
  end

  // Stall is the only combinational output: hold MEM until data can be supplied
  always_comb begin
    ld_stall = 1'b0;
    case (state_q)
      ST_IDLE:    ld_stall = ld_req & ~dc_valid & ~start;
      ST_SPEC:    ld_stall = ld_req;
      ST_RECOVER: ld_stall = ld_req;
      default:    ld_stall = 1'b0;
    endcase
  end

  assign pred_out_valid = pred_out_valid_q;
  assign pred_out       = pred_out_q;
  assign chk_pc         = chk_pc_q;
  assign vp_en          = vp_en_q;
  assign verify_ok      = verify_ok_q;
  assign recover        = recover_q;
  assign recover_busy   = recover_busy_q;
  assign recovery_done  = recovery_done_q;
  assign lvpt_we        = lvpt_we_q;
  assign lvpt_pc        = lvpt_pc_q;
  assign lvpt_data      = lvpt_data_q;
  assign stat_correct   = stat_correct_q;
  assign stat_wrong     = stat_wrong_q;

endmodule
`default_nettype wire

// File: tb/tb_vp_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vp_controller
//  Purpose  : Self-checking bench for vp_controller: directed scenarios with
//             literal expectations plus a cycle-level reference model compared
//             against every output each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vp_controller;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int CB   = 2;
  localparam int RC   = 4;
  localparam int TO   = 8;
  localparam int CMAX = (1 << CB) - 1;
  localparam int CTHR = 1 << (CB - 1);
  localparam logic [AW-1:0] PC = 32'h0040_0100;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_req;
  logic [AW-1:0] ld_pc;
  logic          pred_hit;
  logic [DW-1:0] pred_data;
  logic          dc_valid;
  logic [DW-1:0] dc_data;
  logic          pred_out_valid;
  logic [DW-1:0] pred_out;
  logic [AW-1:0] chk_pc;
  logic          vp_en;
  logic          ld_stall;
  logic          verify_ok;
  logic          recover;
  logic          recover_busy;
  logic          recovery_done;
  logic          lvpt_we;
  logic [AW-1:0] lvpt_pc;
  logic [DW-1:0] lvpt_data;
  logic [15:0]   stat_correct;
  logic [15:0]   stat_wrong;

  vp_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CONF_BITS(CB),
    .RECOVERY_CYCLES(RC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .ld_req(ld_req), .ld_pc(ld_pc),
    .pred_hit(pred_hit), .pred_data(pred_data),
    .dc_valid(dc_valid), .dc_data(dc_data),
    .pred_out_valid(pred_out_valid), .pred_out(pred_out), .chk_pc(chk_pc),
    .vp_en(vp_en), .ld_stall(ld_stall), .verify_ok(verify_ok),
    .recover(recover), .recover_busy(recover_busy), .recovery_done(recovery_done),
    .lvpt_we(lvpt_we), .lvpt_pc(lvpt_pc), .lvpt_data(lvpt_data),
    .stat_correct(stat_correct), .stat_wrong(stat_wrong)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 speculating, 2 recovering
  bit            model_on = 1'b0;
  int            m_mode, m_conf, m_wait, m_rleft;
  logic [DW-1:0] m_sv;
  logic [AW-1:0] m_chk;
  bit            e_pov, e_vok, e_rec, e_we, e_vpen, e_busy, e_done;
  logic [DW-1:0] e_pout, e_ldata;
  logic [AW-1:0] e_lpc;
  int            e_sc, e_sw;

  always @(posedge clk) begin
    if (rst) begin
      model_on = 1'b1;
      m_mode = 0; m_conf = 0; m_wait = 0; m_rleft = 0;
      m_sv = '0; m_chk = '0;
      e_pov = 0; e_vok = 0; e_rec = 0; e_we = 0; e_vpen = 0; e_busy = 0; e_done = 0;
      e_pout = '0; e_ldata = '0; e_lpc = '0; e_sc = 0; e_sw = 0;
    end else if (model_on) begin
      e_pov = 0; e_vok = 0; e_rec = 0; e_we = 0;
      case (m_mode)
        0: begin
          if (ld_req && pred_hit && m_conf >= CTHR && !dc_valid) begin
            m_mode = 1; m_sv = pred_data; m_chk = ld_pc; m_wait = 0;
            e_pov = 1; e_pout = pred_data;
          end else if (ld_req && dc_valid) begin
            e_we = 1; e_lpc = ld_pc; e_ldata = dc_data;
            if (pred_hit) begin
              if (pred_data == dc_data) m_conf = (m_conf < CMAX) ? m_conf + 1 : CMAX;
              else                      m_conf = (m_conf > 0) ? m_conf - 1 : 0;
            end
          end
        end
        1: begin
          if (dc_valid) begin
            e_we = 1; e_lpc = m_chk; e_ldata = dc_data;
            if (dc_data == m_sv) begin
              e_vok = 1; m_mode = 0;
              m_conf = (m_conf < CMAX) ? m_conf + 1 : CMAX;
              e_sc = (e_sc < 16'hFFFF) ? e_sc + 1 : e_sc;
            end else begin
              e_rec = 1; m_mode = 2; m_rleft = RC; m_conf = 0;
              e_sw = (e_sw < 16'hFFFF) ? e_sw + 1 : e_sw;
            end
          end else begin
            m_wait++;
            if (m_wait == TO) begin
              e_rec = 1; m_mode = 2; m_rleft = RC; m_conf = 0;
              e_sw = (e_sw < 16'hFFFF) ? e_sw + 1 : e_sw;
            end
          end
        end
        default: begin
          m_rleft--;
          if (m_rleft == 0) m_mode = 0;
        end
      endcase
      e_vpen = (m_mode == 1);
      e_busy = (m_mode == 2);
      e_done = (m_mode == 2) && (m_rleft == 1);
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    bit exp_stall;
    if (model_on) begin
      if (m_mode == 0)
        exp_stall = ld_req && !dc_valid && !(pred_hit && m_conf >= CTHR);
      else
        exp_stall = ld_req;
      chk("m_pred_out_valid", pred_out_valid, e_pov);
      chk("m_vp_en", vp_en, e_vpen);
      chk("m_verify_ok", verify_ok, e_vok);
      chk("m_recover", recover, e_rec);
      chk("m_recover_busy", recover_busy, e_busy);
      chk("m_recovery_done", recovery_done, e_done);
      chk("m_lvpt_we", lvpt_we, e_we);
      chk("m_stat_correct", stat_correct, e_sc);
      chk("m_stat_wrong", stat_wrong, e_sw);
      chk("m_ld_stall", ld_stall, exp_stall);
      if (e_pov)  chk("m_pred_out", pred_out, e_pout);
      if (e_vpen) chk("m_chk_pc", chk_pc, m_chk);
      if (e_we) begin
        chk("m_lvpt_pc", lvpt_pc, e_lpc);
        chk("m_lvpt_data", lvpt_data, e_ldata);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_req = 0; pred_hit = 0; dc_valid = 0;
  endtask

  // Training load whose data arrives one cycle late (MEM stalls meanwhile)
  task automatic train_slow(input logic [DW-1:0] d);
    ld_req = 1; ld_pc = PC; pred_hit = 1; pred_data = d; dc_valid = 0;
    #1 chk("train_stall_wait", ld_stall, 1);
    tick();
    dc_valid = 1; dc_data = d;
    #1 chk("train_stall_data", ld_stall, 0);
    tick();
    chk("train_we", lvpt_we, 1);
    chk("train_pc", lvpt_pc, PC);
    chk("train_data", lvpt_data, d);
    idle_inputs();
    tick();
  endtask

  // Training load whose data is already present (no speculation possible)
  task automatic train_fast(input logic [DW-1:0] d);
    ld_req = 1; ld_pc = PC; pred_hit = 1; pred_data = d; dc_valid = 1; dc_data = d;
    tick();
    chk("trainf_we", lvpt_we, 1);
    idle_inputs();
    tick();
  endtask

  task automatic start_spec(input logic [DW-1:0] d);
    ld_req = 1; ld_pc = PC; pred_hit = 1; pred_data = d; dc_valid = 0;
    #1 chk("start_no_stall", ld_stall, 0);
    tick();
    chk("spec_pov", pred_out_valid, 1);
    chk("spec_pred_out", pred_out, d);
    chk("spec_vp_en", vp_en, 1);
    chk("spec_chk_pc", chk_pc, PC);
  endtask

  initial begin
    rst = 1; ld_req = 0; ld_pc = '0; pred_hit = 0; pred_data = '0; dc_valid = 0; dc_data = '0;
    tick(); tick();
    chk("rst_pov", pred_out_valid, 0);
    chk("rst_busy", recover_busy, 0);
    chk("rst_we", lvpt_we, 0);
    chk("rst_sc", stat_correct, 0);
    rst = 0;
    tick();

    // Training: confidence 0 -> 3
    train_slow(32'h1234);
    train_slow(32'h1234);
    train_fast(32'h1234);

    // Correct speculation, with a blocked second request while in SPEC
    start_spec(32'h1234);
    #1 chk("spec_block_stall", ld_stall, 1);
    tick();
    chk("spec_no_second_pov", pred_out_valid, 0);
    ld_req = 0; pred_hit = 0; dc_valid = 1; dc_data = 32'h1234;
    tick();
    chk("ok_verify", verify_ok, 1);
    chk("ok_we", lvpt_we, 1);
    chk("ok_data", lvpt_data, 32'h1234);
    chk("ok_sc", stat_correct, 1);
    chk("ok_vp_en", vp_en, 0);
    dc_valid = 0;
    tick();
    chk("ok_pulse_end", verify_ok, 0);

    // Mispredict and 4-cycle recovery
    start_spec(32'h1234);
    ld_req = 0; pred_hit = 0; dc_valid = 1; dc_data = 32'hBEEF;
    tick();
    chk("mp_recover", recover, 1);
    chk("mp_lvpt_data", lvpt_data, 32'hBEEF);
    chk("mp_busy1", recover_busy, 1);
    chk("mp_sw", stat_wrong, 1);
    dc_valid = 0;
    tick();
    chk("mp_rec_pulse_end", recover, 0);
    chk("mp_done2", recovery_done, 0);
    tick();
    chk("mp_done3", recovery_done, 0);
    tick();
    chk("mp_done4", recovery_done, 1);
    chk("mp_busy4", recover_busy, 1);
    tick();
    chk("mp_busy_end", recover_busy, 0);
    // Confidence was cleared: a hit must not speculate now
    ld_req = 1; ld_pc = PC; pred_hit = 1; pred_data = 32'h1234; dc_valid = 0;
    #1 chk("mp_conf0_stall", ld_stall, 1);
    tick();
    chk("mp_conf0_no_pov", pred_out_valid, 0);
    idle_inputs();
    tick();

    // Timeout after TO SPEC cycles
    train_fast(32'h5555);
    train_fast(32'h5555);
    start_spec(32'h5555);
    idle_inputs();
    repeat (TO - 1) tick();
    chk("to_still_spec", vp_en, 1);
    chk("to_not_yet", recover, 0);
    tick();
    chk("to_recover", recover, 1);
    chk("to_no_we", lvpt_we, 0);
    chk("to_sw", stat_wrong, 2);
    repeat (RC) tick();
    chk("to_back_idle", recover_busy, 0);

    // Data on the timeout cycle wins
    train_fast(32'h7777);
    train_fast(32'h7777);
    start_spec(32'h7777);
    idle_inputs();
    repeat (TO - 1) tick();
    dc_valid = 1; dc_data = 32'h7777;
    tick();
    chk("tod_verify", verify_ok, 1);
    chk("tod_no_recover", recover, 0);
    chk("tod_sc", stat_correct, 2);
    dc_valid = 0;
    tick();

    // Reset taken mid-recovery
    start_spec(32'h1111);
    idle_inputs();
    dc_valid = 1; dc_data = 32'h2222;
    tick();
    chk("rr_recover", recover, 1);
    dc_valid = 0;
    tick();
    rst = 1;
    tick();
    chk("rr_busy", recover_busy, 0);
    chk("rr_done", recovery_done, 0);
    chk("rr_sw", stat_wrong, 0);
    chk("rr_sc", stat_correct, 0);
    rst = 0;
    repeat (RC) begin
      tick();
      chk("rr_no_done", recovery_done, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
